// File: rtl/acumulador_com_sinal.sv
// Frame accumulator for signed/unsigned adder results: sums N_AMOSTRAS samples
// with saturation, then holds the result until the consumer accepts it.
module acumulador_com_sinal #(
    parameter int unsigned N_AMOSTRAS  = 8,
    parameter int unsigned LARGURA_ACC = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             entrada,
    input  logic [1:0]             codigo,
    input  logic                   entrada_valida,
    output logic                   entrada_pronta,
    input  logic                   limpar,
    output logic [LARGURA_ACC-1:0] soma,
    output logic [3:0]             amostras,
    output logic                   estouro,
    output logic                   erro_modo,
    output logic                   saida_valida,
    input  logic                   saida_aceita
);

    localparam int unsigned W      = LARGURA_ACC;
    localparam int unsigned CNT_W  = 4;
    localparam logic [CNT_W-1:0] N_ALVO = CNT_W'(N_AMOSTRAS);

    typedef enum logic [1:0] {
        OCIOSO     = 2'd0,
        ACUMULANDO = 2'd1,
        ENTREGA    = 2'd2
    } estado_t;

    estado_t          estado_q, estado_d;
    logic [W-1:0]     soma_q, soma_d;
    logic [CNT_W-1:0] amostras_q, amostras_d;
    logic             estouro_q, estouro_d;
    logic             erro_q, erro_d;
    logic             modo_uns_q, modo_uns_d;

    logic             amostra_uns_c;
    logic [W:0]       soma_ext_c, entrada_ext_c, soma_larga_c;
    logic [W-1:0]     soma_sat_c;
    logic             ovf_c;

    assign amostra_uns_c = (codigo == 2'b01);

    // Extension and saturation follow the mode latched at the frame's first sample.
    always_comb begin
        soma_ext_c    = modo_uns_q ? {1'b0, soma_q} : {soma_q[W-1], soma_q};
        entrada_ext_c = modo_uns_q ? {{(W+1-8){1'b0}}, entrada}
                                   : {{(W+1-8){entrada[7]}}, entrada};
        soma_larga_c  = soma_ext_c + entrada_ext_c;
        if (modo_uns_q) begin
            ovf_c      = soma_larga_c[W];
            soma_sat_c = ovf_c ? {W{1'b1}} : soma_larga_c[W-1:0];
        end else begin
            ovf_c      = soma_larga_c[W] ^ soma_larga_c[W-1];
            soma_sat_c = !ovf_c ? soma_larga_c[W-1:0]
                       : (soma_larga_c[W] ? {1'b1, {(W-1){1'b0}}}
                                          : {1'b0, {(W-1){1'b1}}});
        end
    end

    always_comb begin
        estado_d   = estado_q;
        soma_d     = soma_q;
        amostras_d = amostras_q;
        estouro_d  = estouro_q;
        erro_d     = erro_q;
        modo_uns_d = modo_uns_q;

        if (limpar) begin
            estado_d   = OCIOSO;
            soma_d     = '0;
            amostras_d = '0;
            estouro_d  = 1'b0;
            erro_d     = 1'b0;
            modo_uns_d = 1'b0;
        end else begin
            case (estado_q)
                OCIOSO: begin
                    if (entrada_valida) begin
                        modo_uns_d = amostra_uns_c;
                        soma_d     = amostra_uns_c ? {{(W-8){1'b0}}, entrada}
                                                   : {{(W-8){entrada[7]}}, entrada};
                        amostras_d = CNT_W'(1);
                        estouro_d  = 1'b0;
                        erro_d     = 1'b0;
                        estado_d   = (N_ALVO == CNT_W'(1)) ? ENTREGA : ACUMULANDO;
                    end
                end
                ACUMULANDO: begin
                    if (entrada_valida) begin
                        soma_d     = soma_sat_c;
                        estouro_d  = estouro_q | ovf_c;
                        erro_d     = erro_q | (amostra_uns_c != modo_uns_q);
                        amostras_d = amostras_q + CNT_W'(1);
                        if (amostras_d == N_ALVO) begin
                            estado_d = ENTREGA;
                        end
                    end
                end
                ENTREGA: begin
                    if (saida_aceita) begin
                        estado_d   = OCIOSO;
                        soma_d     = '0;
                        amostras_d = '0;
                        estouro_d  = 1'b0;
                        erro_d     = 1'b0;
                        modo_uns_d = 1'b0;
                    end
                end
                default: begin
                    estado_d = OCIOSO;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q   <= OCIOSO;
            soma_q     <= '0;
            amostras_q <= '0;
            estouro_q  <= 1'b0;
            erro_q     <= 1'b0;
            modo_uns_q <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            soma_q     <= soma_d;
            amostras_q <= amostras_d;
            estouro_q  <= estouro_d;
            erro_q     <= erro_d;
            modo_uns_q <= modo_uns_d;
        end
    end

    assign entrada_pronta = (estado_q != ENTREGA);
    assign saida_valida   = (estado_q == ENTREGA);
    assign soma           = soma_q;
    assign amostras       = amostras_q;
    assign estouro        = estouro_q;
    assign erro_modo      = erro_q;

endmodule

// File: doc/acumulador_com_sinal.md
ACUMULADOR_COM_SINAL -- requirements
Module: acumulador_com_sinal

Interface
REQ-001 SHALL have parameter N_AMOSTRAS, default 8, the number of samples per frame (legal range 1..15).
REQ-002 SHALL have parameter LARGURA_ACC, default 10, the accumulator width in bits (legal range 9..16).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port entrada, input, 8 bits: the result word from the upstream signed/unsigned adder stage.
REQ-006 SHALL have port codigo, input, 2 bits: the operation code that produced entrada (01 = unsigned result; 00/10/11 = signed result).
REQ-007 SHALL have port entrada_valida, input, 1 bit: entrada/codigo are valid this cycle.
REQ-008 SHALL have port entrada_pronta, output, 1 bit: the block can accept a sample this cycle.
REQ-009 SHALL have port limpar, input, 1 bit: synchronous clear of the frame.
REQ-010 SHALL have port soma, output, LARGURA_ACC bits: the frame sum (two's complement in signed mode).
REQ-011 SHALL have port amostras, output, 4 bits: the number of samples accumulated in the current frame.
REQ-012 SHALL have port estouro, output, 1 bit: sticky flag; saturation occurred in the frame.
REQ-013 SHALL have port erro_modo, output, 1 bit: sticky flag; a sample's mode differed from the frame mode.
REQ-014 SHALL have port saida_valida, output, 1 bit: the frame result is available.
REQ-015 SHALL have port saida_aceita, input, 1 bit: the downstream consumer takes the result.

Function
REQ-016 SHALL implement an FSM with states OCIOSO, ACUMULANDO and ENTREGA; all outputs are registered or decoded from state only.
REQ-017 SHALL drive entrada_pronta = 1 in OCIOSO and ACUMULANDO, and 0 in ENTREGA.
REQ-018 SHALL treat a sample as transferred only when entrada_valida & entrada_pronta on a rising edge; with entrada_valida = 0, state and data hold.
REQ-019 SHALL, on a transfer in OCIOSO:
- latch modo (unsigned if codigo == 01, else signed);
- load soma = entrada extended per modo (zero-extended or sign-extended);
- set amostras = 1;
- go to ACUMULANDO, or directly to ENTREGA if N_AMOSTRAS == 1.
REQ-020 SHALL, on a transfer in ACUMULANDO:
- soma = sat(soma + ext(entrada)), using the latched modo for both extension and saturation;
- amostras increments;
- go to ENTREGA when amostras reaches N_AMOSTRAS.
REQ-021 SHALL saturate the sum as follows:
- signed range -2^(LARGURA_ACC-1) .. 2^(LARGURA_ACC-1)-1;
- unsigned range 0 .. 2^LARGURA_ACC-1;
- compute the sum at LARGURA_ACC+1 bits, clamp to the bound, set estouro;
- continue accumulating from the clamped value.
REQ-022 SHALL, when a transferred sample's codigo-derived mode differs from the latched modo, still accumulate it under the latched modo and set erro_modo.
REQ-023 SHALL, in ENTREGA:
- hold saida_valida = 1 and keep soma, amostras, estouro and erro_modo stable;
- ignore entrada_valida.
REQ-024 SHALL, when saida_aceita = 1 in ENTREGA, go to OCIOSO next cycle with saida_valida = 0, soma = 0, amostras = 0 and both flags cleared.
REQ-025 SHALL ignore saida_aceita outside ENTREGA.
REQ-026 SHALL give limpar = 1 priority over every other input in any state:
- next state OCIOSO, all outputs at reset values;
- a transfer or accept in the same cycle is discarded.
REQ-027 SHALL have latency from the final sample's transfer edge to saida_valida = 1 of exactly one clock edge (visible after that edge).

Reset
REQ-028 SHALL, while rst_n = 0, immediately (asynchronously) force:
- state OCIOSO, modo signed;
- soma = 0, amostras = 0, estouro = 0, erro_modo = 0, saida_valida = 0;
- entrada_pronta = 1 once reset is released.
REQ-029 SHALL discard a frame in progress when reset is asserted mid-frame; the first transfer after release starts a new frame.

Verification
REQ-030 SHALL pass: defaults; 8 transfers of 8'hFF with codigo 00 -> saida_valida = 1, soma = 10'h3F8 (-8), amostras = 8, estouro = 0, erro_modo = 0.
REQ-031 SHALL pass: 8 transfers of 8'hFF with codigo 01 -> soma = 10'h3FF (1023), estouro = 1; and 8 transfers of 8'h80 with codigo 00 -> soma = 10'h200 (-512), estouro = 1.
REQ-032 SHALL pass: frame completes, saida_aceita held 0 for 5 cycles while entrada_valida = 1 -> saida_valida stays 1, entrada_pronta = 0, soma unchanged; saida_aceita pulse -> OCIOSO and outputs cleared the next cycle.
REQ-033 SHALL pass: first sample 8'h10 with codigo 01, then 7 samples 8'h10 with codigo 00 -> erro_modo = 1, soma = 10'h080 (unsigned accumulation).
REQ-034 SHALL pass: 3 samples of 8'h05, then limpar asserted together with entrada_valida -> amostras = 0, soma = 0; next 8 samples of 8'h01 -> soma = 8.
REQ-035 SHALL pass: rst_n asserted low mid-clock-cycle after 4 samples -> outputs clear without a clock edge; N_AMOSTRAS = 1 build: single 8'h7F transfer -> saida_valida = 1 next edge, soma = 10'h07F.
